// File: rtl/rsp_ldgen32.sv
// Register-file load strobe generator: 2-deep request FIFO feeding a LOAD/HOLD sequencer.
// Latency: accept edge N -> LOAD cycle after edge N+1; req_ready drops when both FIFO entries are occupied.
module rsp_ldgen32 #(
  parameter int unsigned HOLD = 1
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_addr,
  input  logic        req_all,
  input  logic [31:0] req_data,
  output logic [31:0] ld_bar,
  output logic [31:0] wr_data,
  output logic        busy
);

  typedef struct packed {
    logic [4:0]  addr;
    logic        all;
    logic [31:0] data;
  } req_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam bit         HAS_HOLD  = (HOLD != 0);
  localparam logic [1:0] HOLD_LAST = (HOLD == 0) ? 2'd0 : 2'(HOLD - 1);

  req_t       fifo_mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic [1:0] state;
  logic [1:0] hold_cnt;
  logic       push;
  logic       pop;
  req_t       head;

  // Ready looks only at the registered count, so a full FIFO never takes a push even when popping.
  assign req_ready = (count != 2'd2);
  assign push      = req_valid & req_ready;
  assign pop       = (state == ST_IDLE) && (count != 2'd0);
  assign head      = fifo_mem[rd_ptr];
  assign busy      = (count != 2'd0) || (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {req_addr, req_all, req_data};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Strobes and data are registered so the downstream clock-OR latch enables stay glitch-free.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state    <= ST_IDLE;
      hold_cnt <= 2'd0;
      ld_bar   <= '1;
      wr_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            state   <= ST_LOAD;
            ld_bar  <= head.all ? 32'h0000_0000 : ~(32'd1 << head.addr);
            wr_data <= head.data;
          end
        end
        ST_LOAD: begin
          ld_bar <= '1;
          if (HAS_HOLD) begin
            state    <= ST_HOLD;
            hold_cnt <= HOLD_LAST;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == 2'd0) begin
            state <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt - 2'd1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          ld_bar <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsp_ldgen32.sv
// Bench for rsp_ldgen32: HOLD=1 instance driven by a vector table and scoreboard, HOLD=0 instance
// exercised by a hand sequence; strobe shape and edge alignment are watched on every cycle.
module tb_rsp_ldgen32;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_addr = '0;
  logic        req_all = 1'b0;
  logic [31:0] req_data = '0;
  logic [31:0] ld_bar;
  logic [31:0] wr_data;
  logic        busy;

  logic        req_valid0 = 1'b0;
  logic        req_ready0;
  logic [4:0]  req_addr0 = '0;
  logic        req_all0 = 1'b0;
  logic [31:0] req_data0 = '0;
  logic [31:0] ld_bar0;
  logic [31:0] wr_data0;
  logic        busy0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] ld;
    logic [31:0] wr;
  } exp_t;

  typedef struct {
    logic [4:0]  addr;
    logic        all;
    logic [31:0] data;
    logic [31:0] exp_ld;
    logic [31:0] exp_wr;
  } vec_t;

  exp_t exp_q[$];
  time  load_times[$];
  time  last_edge = 0;

  rsp_ldgen32 #(.HOLD(1)) u_dut (
    .clk       (clk),
    .reset_l   (reset_l),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_all   (req_all),
    .req_data  (req_data),
    .ld_bar    (ld_bar),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  rsp_ldgen32 #(.HOLD(0)) u_dut0 (
    .clk       (clk),
    .reset_l   (reset_l),
    .req_valid (req_valid0),
    .req_ready (req_ready0),
    .req_addr  (req_addr0),
    .req_all   (req_all0),
    .req_data  (req_data0),
    .ld_bar    (ld_bar0),
    .wr_data   (wr_data0),
    .busy      (busy0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ld_ok(input logic [31:0] v);
    return ((v == 32'h0) || ($countones(~v) <= 1)) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] model_ld(input logic [4:0] a, input logic al);
    return al ? 32'h0 : ~(32'd1 << a);
  endfunction

  always @(posedge clk) last_edge = $time;

  // Strobe edges must coincide with a rising clock edge unless reset is forcing them.
  always @(ld_bar) begin
    if (reset_l) begin
      checks++;
      if ($time != last_edge) begin
        errors++;
        $display("FAIL ld_bar_edge: changed at %0t, last clk edge %0t", $time, last_edge);
      end
    end
  end

  always @(ld_bar0) begin
    if (reset_l) begin
      checks++;
      if ($time != last_edge) begin
        errors++;
        $display("FAIL ld_bar0_edge: changed at %0t, last clk edge %0t", $time, last_edge);
      end
    end
  end

  always @(negedge reset_l) exp_q.delete();

  always @(negedge clk) begin
    if (reset_l) begin
      chk("ld_bar_shape", ld_ok(ld_bar), 32'd1);
      chk("ld_bar0_shape", ld_ok(ld_bar0), 32'd1);
      if (ld_bar != 32'hFFFF_FFFF) begin
        exp_t e;
        load_times.push_back($time);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load: got ld_bar %h expected no strobe", ld_bar);
        end else begin
          e = exp_q.pop_front();
          chk("sb_ld_bar", ld_bar, e.ld);
          chk("sb_wr_data", wr_data, e.wr);
        end
      end
    end
  end

  task automatic send(input logic [4:0] a, input logic al, input logic [31:0] d,
                      input logic [31:0] exp_ld);
    bit ok = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    req_all   = al;
    req_data  = d;
    for (int t = 0; t < 40 && !ok; t++) begin
      if (req_ready) begin
        @(posedge clk);
        exp_q.push_back('{exp_ld, d});
        ok = 1'b1;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got req_ready 0 for addr %0d expected acceptance", a);
    end
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 60 && busy; t++) @(negedge clk);
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{5'd5,  1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFDF, 32'hDEAD_BEEF};
    vecs[1] = '{5'd0,  1'b0, 32'h1234_5678, 32'hFFFF_FFFE, 32'h1234_5678};
    vecs[2] = '{5'd31, 1'b0, 32'hA5A5_A5A5, 32'h7FFF_FFFF, 32'hA5A5_A5A5};
    vecs[3] = '{5'd9,  1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{5'd16, 1'b0, 32'hFFFF_FFFF, 32'hFFFE_FFFF, 32'hFFFF_FFFF};
    vecs[5] = '{5'd3,  1'b1, 32'hCAFE_F00D, 32'h0000_0000, 32'hCAFE_F00D};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ld_bar", ld_bar, 32'hFFFF_FFFF);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_ld_bar0", ld_bar0, 32'hFFFF_FFFF);
    chk("rst_busy0", {31'd0, busy0}, 32'd0);

    // Single write, first request right after reset release
    reset_l = 1'b1;
    send(5'd5, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFDF);
    idle();
    chk("w1_e1_busy", {31'd0, busy}, 32'd1);
    chk("w1_e1_ld_bar", ld_bar, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("w1_load_ld_bar", ld_bar, 32'hFFFF_FFDF);
    chk("w1_load_wr", wr_data, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("w1_hold_ld_bar", ld_bar, 32'hFFFF_FFFF);
    chk("w1_hold_wr", wr_data, 32'hDEAD_BEEF);
    chk("w1_hold_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("w1_idle_busy", {31'd0, busy}, 32'd0);
    chk("w1_idle_wr", wr_data, 32'hDEAD_BEEF);

    // Vector table
    foreach (vecs[i]) begin
      send(vecs[i].addr, vecs[i].all, vecs[i].data, vecs[i].exp_ld);
      idle();
      wait_idle();
      chk("vec_wr_retained", wr_data, vecs[i].exp_wr);
      chk("vec_ld_bar_idle", ld_bar, 32'hFFFF_FFFF);
    end

    // Back-pressure: four back-to-back requests
    load_times.delete();
    send(5'd1, 1'b0, 32'h0000_0001, model_ld(5'd1, 1'b0));
    send(5'd2, 1'b0, 32'h0000_0002, model_ld(5'd2, 1'b0));
    send(5'd3, 1'b0, 32'h0000_0003, model_ld(5'd3, 1'b0));
    chk("bp_ready_full", {31'd0, req_ready}, 32'd0);
    chk("bp_busy", {31'd0, busy}, 32'd1);
    send(5'd4, 1'b0, 32'h0000_0004, model_ld(5'd4, 1'b0));
    idle();
    wait_idle();
    chk("bp_load_count", 32'(load_times.size()), 32'd4);
    for (int i = 1; i < load_times.size(); i++)
      chk("bp_spacing", 32'(load_times[i] - load_times[i-1]), 32'd30);
    chk("bp_sb_drained", 32'(exp_q.size()), 32'd0);

    // HOLD=0 instance: two queued writes
    req_valid0 = 1'b1;
    req_addr0  = 5'd31;
    req_data0  = 32'h1111_1111;
    chk("h0_ready", {31'd0, req_ready0}, 32'd1);
    @(negedge clk);
    req_addr0 = 5'd0;
    req_data0 = 32'h2222_2222;
    chk("h0_ready2", {31'd0, req_ready0}, 32'd1);
    @(negedge clk);
    req_valid0 = 1'b0;
    chk("h0_load1_ld", ld_bar0, 32'h7FFF_FFFF);
    chk("h0_load1_wr", wr_data0, 32'h1111_1111);
    @(negedge clk);
    chk("h0_gap_ld", ld_bar0, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("h0_load2_ld", ld_bar0, 32'hFFFF_FFFE);
    chk("h0_load2_wr", wr_data0, 32'h2222_2222);
    @(negedge clk);
    chk("h0_end_ld", ld_bar0, 32'hFFFF_FFFF);
    chk("h0_end_busy", {31'd0, busy0}, 32'd0);

    // Reset in the middle of a LOAD with a second request queued
    send(5'd7, 1'b0, 32'h7777_7777, 32'hFFFF_FF7F);
    send(5'd8, 1'b0, 32'h8888_8888, 32'hFFFF_FEFF);
    idle();
    chk("rl_in_load", ld_bar, 32'hFFFF_FF7F);
    #2 reset_l = 1'b0;
    #1;
    chk("rl_ld_bar", ld_bar, 32'hFFFF_FFFF);
    chk("rl_wr_data", wr_data, 32'h0);
    chk("rl_busy", {31'd0, busy}, 32'd0);
    chk("rl_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
    load_times.delete();
    repeat (10) @(negedge clk);
    chk("rl_no_strobe", 32'(load_times.size()), 32'd0);
    chk("rl_post_busy", {31'd0, busy}, 32'd0);
    send(5'd12, 1'b0, 32'h0C0C_0C0C, 32'hFFFF_EFFF);
    idle();
    wait_idle();
    chk("rl_new_load", 32'(load_times.size()), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by %0t expected completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/rsp_ldgen32.md
RSP_LDGEN32 -- requirements
Module: rsp_ldgen32

Interface
REQ-001 Parameter: HOLD, default 1, number of data-hold cycles after each load pulse (legal 0..3).
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset_l  input  1  asynchronous reset, active-low.
REQ-004 Port: req_valid  input  1  write request present.
REQ-005 Port: req_ready  output  1  block can accept a request this cycle.
REQ-006 Port: req_addr  input  5  target register index 0..31.
REQ-007 Port: req_all  input  1  broadcast; write all 32 registers, req_addr ignored.
REQ-008 Port: req_data  input  32  write data.
REQ-009 Port: ld_bar  output  32  per-register active-low load strobes, feeding the clock-gated latch enables.
REQ-010 Port: wr_data  output  32  data bus to the register latches.
REQ-011 Port: busy  output  1  request queued or write sequence in progress.

Function
REQ-012 Handshake: a request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; addr, all and data SHALL be captured into a 2-entry FIFO.
REQ-013 req_ready SHALL equal NOT full, from registered FIFO count only; no same-cycle push-through when full, even if a pop occurs in that cycle.
REQ-014 FIFO SHALL preserve acceptance order; pointers wrap modulo 2; a simultaneous push and pop with count=1 SHALL leave count=1.
REQ-015 The sequencer FSM SHALL have states IDLE, LOAD, HOLD.
REQ-016 IDLE: if FIFO non-empty, pop head and enter LOAD at the next edge; otherwise stay in IDLE.
REQ-017 LOAD lasts exactly 1 cycle: ld_bar[req_addr]=0, all other bits=1, or ld_bar=0x00000000 if all=1; wr_data = popped data.
REQ-018 LOAD exit: HOLD if HOLD>0, else IDLE.
REQ-019 HOLD lasts exactly HOLD cycles, counted by a 2-bit counter: ld_bar=0xFFFFFFFF, wr_data unchanged; then IDLE.
REQ-020 IDLE SHALL drive ld_bar=0xFFFFFFFF; wr_data SHALL keep its last value.
REQ-021 ld_bar and wr_data SHALL be driven directly from flops, changing only at rising clk edges, so the OR-with-clk enable never glitches.
REQ-022 Latency: a request accepted at edge N with FIFO empty and FSM in IDLE SHALL produce LOAD in the cycle after edge N+1.
REQ-023 Throughput: successive writes SHALL issue LOAD every 2+HOLD cycles.
REQ-024 In LOAD, at most one ld_bar bit SHALL be low unless all=1; no ld_bar bit SHALL be low outside LOAD.
REQ-025 busy SHALL be 1 when the FIFO is non-empty or the FSM is not in IDLE, and 0 otherwise.

Reset
REQ-026 While reset_l=0, and immediately on its assertion: ld_bar=0xFFFFFFFF, wr_data=0, FIFO empty, FSM=IDLE, hold counter=0, busy=0, req_ready=1.
REQ-027 Reset asserted mid-sequence SHALL abort any LOAD or HOLD and discard queued requests; no load pulse SHALL follow deassertion without a new request.
REQ-028 The first request SHALL be accepted at the first rising edge after reset_l rises.

Verification
REQ-029 Single write, HOLD=1: addr=5, data=0xDEADBEEF accepted at edge 1 -> ld_bar=0xFFFFFFDF and wr_data=0xDEADBEEF for one cycle after edge 2; ld_bar=0xFFFFFFFF after edge 3 with wr_data still 0xDEADBEEF; busy=0 after edge 4.
REQ-030 Broadcast: all=1, data=0 -> one LOAD cycle with ld_bar=0x00000000 and wr_data=0.
REQ-031 Back-pressure: req_valid held high with addrs 1,2,3,4 on consecutive edges -> req_ready=0 while 2 entries are queued; all four LOADs issue in order 1,2,3,4, spaced 3 cycles apart.
REQ-032 HOLD=0: two queued writes, addrs 31 and 0 -> LOAD cycles 2 clocks apart; ld_bar=0x7FFFFFFF then 0xFFFFFFFE.
REQ-033 Reset during LOAD for addr 7 -> ld_bar=0xFFFFFFFF asynchronously; FIFO empty; after release, no strobe until a new request is accepted.
REQ-034 A bench checker SHALL confirm, every cycle, that REQ-024 holds and that ld_bar changes only at rising clk edges.
